// File: rtl/bitwise_reduce_accum_if.sv
// bitwise_reduce_accum_if: operand/result handshake bundle for bitwise_reduce_accum.
// Signals:
//   op        3      operation code, taken with the first operand of a group
//   in_valid  1      operand present
//   in_ready  1      unit accepts operand
//   in_data   WIDTH  operand
//   in_last   1      ends a group early (only with BITWISE_REDUCE_EARLY_LAST_EN)
//   out_valid 1      result present
//   out_ready 1      consumer accepts result
//   out_data  WIDTH  group result
//   op_err    1      reserved op used for the presented result
// Modports: master = producer/consumer side, slave = the reduction unit.
interface bitwise_reduce_accum_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
`ifdef BITWISE_REDUCE_EARLY_LAST_EN
    logic             in_last;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             op_err;

    modport master (
        output op, in_valid, in_data, out_ready,
`ifdef BITWISE_REDUCE_EARLY_LAST_EN
        output in_last,
`endif
        input  in_ready, out_valid, out_data, op_err
    );

    modport slave (
        input  op, in_valid, in_data, out_ready,
`ifdef BITWISE_REDUCE_EARLY_LAST_EN
        input  in_last,
`endif
        output in_ready, out_valid, out_data, op_err
    );
endinterface

// File: rtl/bitwise_reduce_accum.sv
// bitwise_reduce_accum: streaming fold of N_OPS operands with OR/AND/XOR/NOR/NAND/XNOR.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    bitwise_reduce_accum_if.slave (op, in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data, op_err)
// Optional macro BITWISE_REDUCE_EARLY_LAST_EN: an accepted operand with
// bus.in_last=1 closes the group early (groups of 1..N_OPS operands).
module bitwise_reduce_accum #(
    parameter int WIDTH = 8,
    parameter int N_OPS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bitwise_reduce_accum_if.slave  bus
);
    localparam int CW = $clog2(N_OPS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_OPS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, out_data_q, fold, res_pre, res;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q, op_cur;
    logic             err_q, out_valid_q, op_err_q;
    logic             in_ready, accept, last, inv, err, to_hold;

    function automatic logic [WIDTH-1:0] base_op(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        return (o == 3'b001 || o == 3'b100) ? (a & b) :
               (o == 3'b010 || o == 3'b101) ? (a ^ b) : (a | b);
    endfunction

    function automatic logic is_inv(input logic [2:0] o);
        return o == 3'b011 || o == 3'b100 || o == 3'b101;
    endfunction

    assign in_ready      = state != HOLD;
    assign accept        = bus.in_valid & in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.op_err    = op_err_q;

    always_comb begin
        // First operand of a group uses the live op; later ones the captured op.
        op_cur  = state == IDLE ? bus.op : op_q;
        fold    = base_op(op_cur, acc, bus.in_data);
        res_pre = state == IDLE ? bus.in_data : fold;
        inv     = is_inv(op_cur);
        res     = inv ? ~res_pre : res_pre;
        err     = state == IDLE ? (bus.op[2] & bus.op[1]) : err_q;
        last    = state == IDLE ? (N_OPS == 1) : (cnt == CNT_LAST);
`ifdef BITWISE_REDUCE_EARLY_LAST_EN
        last    = last | bus.in_last;
`endif
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (last ? HOLD : ACCUM) : IDLE;
            ACCUM:   state_nx = (accept && last) ? HOLD : ACCUM;
            HOLD:    state_nx = bus.out_ready ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
        to_hold = state != HOLD && state_nx == HOLD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            op_q        <= 3'b000;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            op_err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                acc <= res_pre;
                cnt <= state == IDLE ? CW'(1) : cnt + 1'b1;
                if (state == IDLE) begin
                    op_q  <= bus.op;
                    err_q <= bus.op[2] & bus.op[1];
                end
            end
            if (to_hold) begin
                out_data_q  <= res;
                out_valid_q <= 1'b1;
                op_err_q    <= err;
            end
            if (state == HOLD && bus.out_ready) begin
                out_valid_q <= 1'b0;
                op_err_q    <= 1'b0;
                cnt         <= '0;
            end
        end
    end
endmodule

// File: tb/tb_bitwise_reduce_accum.sv
// tb_bitwise_reduce_accum: directed self-checking bench for bitwise_reduce_accum (N_OPS=4 and N_OPS=1).
module tb_bitwise_reduce_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bitwise_reduce_accum_if #(.WIDTH(8)) b();
    bitwise_reduce_accum_if #(.WIDTH(8)) b1();

    bitwise_reduce_accum #(.WIDTH(8), .N_OPS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    bitwise_reduce_accum #(.WIDTH(8), .N_OPS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] o, input logic [7:0] d, input logic l);
        int t = 0;
        b.op = o;
        b.in_data = d;
        b.in_valid = 1'b1;
`ifdef BITWISE_REDUCE_EARLY_LAST_EN
        b.in_last = l;
`else
        if (l) $display("note: in_last ignored in this build");
`endif
        while (!b.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!b.in_ready) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        b.in_valid = 1'b0;
`ifdef BITWISE_REDUCE_EARLY_LAST_EN
        b.in_last = 1'b0;
`endif
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        b.op = 3'b000; b.in_valid = 1'b0; b.in_data = 8'h00; b.out_ready = 1'b1;
        b1.op = 3'b000; b1.in_valid = 1'b0; b1.in_data = 8'h00; b1.out_ready = 1'b1;
`ifdef BITWISE_REDUCE_EARLY_LAST_EN
        b.in_last = 1'b0;
        b1.in_last = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_out_valid", 32'(b.out_valid), 32'd0);
        check("rst_in_ready", 32'(b.in_ready), 32'd1);
        check("rst_out_data", 32'(b.out_data), 32'h00);
        check("rst_op_err", 32'(b.op_err), 32'd0);

        // OR group, back to back
        push(3'b000, 8'h01, 1'b0);
        push(3'b000, 8'h02, 1'b0);
        check("or_not_yet_valid", 32'(b.out_valid), 32'd0);
        push(3'b000, 8'h04, 1'b0);
        push(3'b000, 8'h80, 1'b0);
        check("or_valid", 32'(b.out_valid), 32'd1);
        check("or_data", 32'(b.out_data), 32'h87);
        check("or_err", 32'(b.op_err), 32'd0);
        check("or_in_ready_hold", 32'(b.in_ready), 32'd0);
        cycle();
        check("or_valid_fall", 32'(b.out_valid), 32'd0);
        check("or_data_retained", 32'(b.out_data), 32'h87);
        check("or_in_ready_back", 32'(b.in_ready), 32'd1);

        // NAND with op switched mid-group and idle gaps in ACCUM
        push(3'b100, 8'hFF, 1'b0);
        push(3'b000, 8'hF0, 1'b0);
        cycle();
        cycle();
        check("nand_gap_no_result", 32'(b.out_valid), 32'd0);
        push(3'b000, 8'h3C, 1'b0);
        push(3'b000, 8'hFF, 1'b0);
        check("nand_valid", 32'(b.out_valid), 32'd1);
        check("nand_data", 32'(b.out_data), 32'hCF);
        cycle();

        // XOR with op switched mid-group
        push(3'b010, 8'hAA, 1'b0);
        push(3'b000, 8'h55, 1'b0);
        push(3'b000, 8'h0F, 1'b0);
        push(3'b000, 8'h00, 1'b0);
        check("xor_data", 32'(b.out_data), 32'hF0);
        check("xor_valid", 32'(b.out_valid), 32'd1);
        cycle();

        // Backpressure: result held, offered operand not consumed
        b.out_ready = 1'b0;
        push(3'b000, 8'h01, 1'b0);
        push(3'b000, 8'h02, 1'b0);
        push(3'b000, 8'h04, 1'b0);
        push(3'b000, 8'h08, 1'b0);
        b.op = 3'b010; b.in_data = 8'h55; b.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(b.out_valid), 32'd1);
            check("bp_data", 32'(b.out_data), 32'h0F);
            check("bp_in_ready", 32'(b.in_ready), 32'd0);
            cycle();
        end
        b.out_ready = 1'b1;
        cycle();
        check("bp_valid_fall", 32'(b.out_valid), 32'd0);
        check("bp_in_ready_back", 32'(b.in_ready), 32'd1);
        // A 55 wrongly taken during HOLD would make this XOR group 55^55 = 00
        push(3'b010, 8'h55, 1'b0);
        push(3'b000, 8'h00, 1'b0);
        push(3'b000, 8'h00, 1'b0);
        push(3'b000, 8'h00, 1'b0);
        check("bp_next_group", 32'(b.out_data), 32'h55);
        cycle();

        // Reset mid-group discards partial data
        push(3'b000, 8'hFF, 1'b0);
        push(3'b000, 8'hFF, 1'b0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(b.in_ready), 32'd1);
        check("midrst_out_valid", 32'(b.out_valid), 32'd0);
        check("midrst_out_data", 32'(b.out_data), 32'h00);
        push(3'b000, 8'h00, 1'b0);
        push(3'b000, 8'h00, 1'b0);
        push(3'b000, 8'h00, 1'b0);
        push(3'b000, 8'h01, 1'b0);
        check("midrst_fresh", 32'(b.out_data), 32'h01);
        check("midrst_fresh_valid", 32'(b.out_valid), 32'd1);
        cycle();

        // Reserved op folds as OR with op_err
        push(3'b111, 8'h10, 1'b0);
        push(3'b000, 8'h20, 1'b0);
        push(3'b000, 8'h40, 1'b0);
        push(3'b000, 8'h80, 1'b0);
        check("rsv_data", 32'(b.out_data), 32'hF0);
        check("rsv_err", 32'(b.op_err), 32'd1);
        cycle();
        check("rsv_err_clear", 32'(b.op_err), 32'd0);
        push(3'b001, 8'hFF, 1'b0);
        push(3'b000, 8'hFF, 1'b0);
        push(3'b000, 8'hFF, 1'b0);
        push(3'b000, 8'h7F, 1'b0);
        check("and_data", 32'(b.out_data), 32'h7F);
        check("and_err", 32'(b.op_err), 32'd0);
        cycle();

`ifdef BITWISE_REDUCE_EARLY_LAST_EN
        push(3'b000, 8'h01, 1'b0);
        push(3'b000, 8'h10, 1'b1);
        check("early_valid", 32'(b.out_valid), 32'd1);
        check("early_data", 32'(b.out_data), 32'h11);
        cycle();
`endif

        // N_OPS=1: every operand is a group
        b1.op = 3'b011; b1.in_data = 8'h00; b1.in_valid = 1'b1;
        cycle();
        check("n1_valid", 32'(b1.out_valid), 32'd1);
        check("n1_nor", 32'(b1.out_data), 32'hFF);
        b1.op = 3'b000; b1.in_data = 8'h5A;
        cycle();
        check("n1_valid_fall", 32'(b1.out_valid), 32'd0);
        cycle();
        b1.in_valid = 1'b0;
        check("n1_or_valid", 32'(b1.out_valid), 32'd1);
        check("n1_or", 32'(b1.out_data), 32'h5A);
        cycle();
        check("n1_idle", 32'(b1.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
